// File: rtl/openip_weighted_rr_arbiter_if.sv
// Handshake bundle between WIDTH requesters, the weighted round-robin arbiter
// and its single downstream channel.
interface openip_weighted_rr_arbiter_if #(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0]          req_valid;
  logic [WIDTH-1:0]          req_last;
  logic [WIDTH-1:0]          req_ready;
  logic [WIDTH*WEIGHT_W-1:0] weight;
  logic [WIDTH-1:0]          grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    output req_valid, req_last, weight, out_ready,
    input  req_ready, grant, grant_idx, out_valid, out_last
  );

  modport slave (
    input  req_valid, req_last, weight, out_ready,
    output req_ready, grant, grant_idx, out_valid, out_last
  );
endinterface

// File: rtl/openip_weighted_rr_arbiter.sv
// Packet-locking weighted round-robin arbiter; define OPENIP_WRR_WEIGHT_EN for
// per-requester weights, otherwise plain round-robin with packet locking.
//
// state  | meaning
// IDLE   | no packet in flight; grant is the combinational pick
// LOCKED | multi-beat packet in flight; grant held at owner until its last beat
module openip_weighted_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4
) (
  input logic                        clk,
  input logic                        rst,
  openip_weighted_rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2) begin : g_width_check
    $error("openip_weighted_rr_arbiter needs WIDTH >= 2");
  end

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] last_grant_q, last_grant_d;
  logic [WIDTH-1:0] above, masked, lowest_masked, lowest_all, pick;
  logic [WIDTH-1:0] grant_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic             hold;
  logic             out_valid_c, out_last_c, complete;

`ifdef OPENIP_WRR_WEIGHT_EN
  localparam logic [WEIGHT_W-1:0] ONE_W = {{(WEIGHT_W-1){1'b0}}, 1'b1};

  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] weight_sel;

  assign hold = (|(bus.req_valid & last_grant_q)) && (credit_q != '0);

  always_comb begin
    weight_sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (grant_c[i]) weight_sel = bus.weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end
`else
  logic unused_weight;

  assign hold          = 1'b0;
  assign unused_weight = ^bus.weight;
`endif

  // Bits strictly above the one-hot last_grant; empty when last_grant is 0,
  // which makes the fallback (lowest valid overall) the unmasked pick.
  assign above         = ~(last_grant_q | (last_grant_q - ONE));
  assign masked        = bus.req_valid & above;
  assign lowest_masked = masked & (~masked + ONE);
  assign lowest_all    = bus.req_valid & (~bus.req_valid + ONE);

  always_comb begin
    if (hold)           pick = last_grant_q;
    else if (|masked)   pick = lowest_masked;
    else                pick = lowest_all;
  end

  always_comb begin
    if (rst)                      grant_c = '0;
    else if (state_q == ST_IDLE)  grant_c = pick;
    else                          grant_c = owner_q;
  end

  always_comb begin
    grant_idx_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (grant_c[i]) grant_idx_c = i[IDX_W-1:0];
    end
  end

  assign out_valid_c = |(bus.req_valid & grant_c);
  assign out_last_c  = |(bus.req_last & grant_c);
  assign complete    = out_valid_c & bus.out_ready & out_last_c;

  assign bus.grant     = grant_c;
  assign bus.grant_idx = grant_idx_c;
  assign bus.req_ready = grant_c & {WIDTH{bus.out_ready}};
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
`ifdef OPENIP_WRR_WEIGHT_EN
    credit_d     = credit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((grant_c != '0) && !complete) begin
          owner_d = grant_c;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (complete) begin
          owner_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      last_grant_d = grant_c;
`ifdef OPENIP_WRR_WEIGHT_EN
      // Repeat winner spends a credit; a new winner loads weight-1 (weight 0 acts as 1).
      if (grant_c == last_grant_q)
        credit_d = (credit_q == '0) ? '0 : credit_q - ONE_W;
      else
        credit_d = (weight_sel == '0) ? '0 : weight_sel - ONE_W;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= '0;
`ifdef OPENIP_WRR_WEIGHT_EN
      credit_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
`ifdef OPENIP_WRR_WEIGHT_EN
      credit_q     <= credit_d;
`endif
    end
  end
endmodule

// File: tb/tb_openip_weighted_rr_arbiter.sv
// Self-checking bench: directed vector table plus randomized packet traffic
// checked against an index-based reference model.
module tb_openip_weighted_rr_arbiter;
  localparam int WIDTH    = 4;
  localparam int WEIGHT_W = 4;
  localparam int NVEC     = 32;
`ifdef OPENIP_WRR_WEIGHT_EN
  localparam bit WEIGHTED = 1'b1;
`else
  localparam bit WEIGHTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  openip_weighted_rr_arbiter_if #(.WIDTH(WIDTH), .WEIGHT_W(WEIGHT_W)) bus ();

  openip_weighted_rr_arbiter #(.WIDTH(WIDTH), .WEIGHT_W(WEIGHT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: owner index (-1 = idle), last winner (-1 = none), credit.
  int m_owner  = -1;
  int m_last   = -1;
  int m_credit = 0;

  typedef struct {
    logic                      rst;
    logic [WIDTH-1:0]          valid;
    logic [WIDTH-1:0]          last;
    logic                      ready;
    logic [WIDTH*WEIGHT_W-1:0] weight;
    logic [WIDTH-1:0]          exp_grant;
  } vec_t;

  vec_t tbl[NVEC];

  function automatic int model_pick(input logic [WIDTH-1:0] v);
    if (m_owner >= 0) return m_owner;
    if (WEIGHTED && m_last >= 0 && v[m_last] && m_credit > 0) return m_last;
    for (int i = m_last + 1; i < WIDTH; i++) if (v[i]) return i;
    for (int i = 0; i < WIDTH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] l,
                      input logic rd, input logic [WIDTH*WEIGHT_W-1:0] w,
                      output logic [WIDTH-1:0] g_exp, output logic [WIDTH-1:0] g_act);
    int gi;
    int wk;
    rst           = r;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.out_ready = rd;
    bus.weight    = w;
    @(negedge clk);
    gi    = r ? -1 : model_pick(v);
    g_exp = (gi < 0) ? '0 : (WIDTH'(1) << gi);
    g_act = bus.grant;
    check("grant",     32'(bus.grant),     32'(g_exp));
    check("grant_idx", 32'(bus.grant_idx), (gi < 0) ? 32'd0 : 32'(gi));
    check("req_ready", 32'(bus.req_ready), 32'(g_exp & {WIDTH{rd}}));
    check("out_valid", 32'(bus.out_valid), 32'(|(v & g_exp)));
    check("out_last",  32'(bus.out_last),  32'(|(l & g_exp)));
    @(posedge clk);
    if (r) begin
      m_owner = -1; m_last = -1; m_credit = 0;
    end else if (gi >= 0) begin
      if (v[gi] && rd && l[gi]) begin
        if (gi == m_last) m_credit = (m_credit > 0) ? m_credit - 1 : 0;
        else begin
          wk = int'(w[gi*WEIGHT_W +: WEIGHT_W]);
          m_credit = (wk == 0) ? 0 : wk - 1;
        end
        m_last  = gi;
        m_owner = -1;
      end else begin
        m_owner = gi;
      end
    end
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic rd, input logic [15:0] w, input logic [3:0] e);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.ready = rd; t.weight = w; t.exp_grant = e;
    return t;
  endfunction

  logic [WIDTH-1:0]          ge, ga, v, l;
  logic [WIDTH*WEIGHT_W-1:0] w;
  logic                      r, rd;
  bit                        act [WIDTH];
  int                        left[WIDTH];

  initial begin
    rst = 1'b1; bus.req_valid = '0; bus.req_last = '0; bus.out_ready = 1'b0; bus.weight = '0;

    // Round-robin between 1 and 3, single-beat packets.
    tbl[0]  = mk(1, 4'b1010, 4'b1111, 1, 16'h1111, 4'b0000);
    tbl[1]  = mk(0, 4'b1010, 4'b1111, 1, 16'h1111, 4'b0010);
    tbl[2]  = mk(0, 4'b1010, 4'b1111, 1, 16'h1111, 4'b1000);
    tbl[3]  = mk(0, 4'b1010, 4'b1111, 1, 16'h1111, 4'b0010);
    tbl[4]  = mk(0, 4'b1010, 4'b1111, 1, 16'h1111, 4'b1000);
    // Three-beat packet from 0 while 1 waits.
    tbl[5]  = mk(0, 4'b0011, 4'b0010, 1, 16'h1111, 4'b0001);
    tbl[6]  = mk(0, 4'b0011, 4'b0000, 1, 16'h1111, 4'b0001);
    tbl[7]  = mk(0, 4'b0011, 4'b0001, 1, 16'h1111, 4'b0001);
    tbl[8]  = mk(0, 4'b0011, 4'b0011, 1, 16'h1111, 4'b0010);
    // Same packet with a two-cycle downstream stall.
    tbl[9]  = mk(0, 4'b0011, 4'b0010, 1, 16'h1111, 4'b0001);
    tbl[10] = mk(0, 4'b0011, 4'b0010, 0, 16'h1111, 4'b0001);
    tbl[11] = mk(0, 4'b0011, 4'b0010, 0, 16'h1111, 4'b0001);
    tbl[12] = mk(0, 4'b0011, 4'b0000, 1, 16'h1111, 4'b0001);
    tbl[13] = mk(0, 4'b0011, 4'b0001, 1, 16'h1111, 4'b0001);
    tbl[14] = mk(0, 4'b0011, 4'b0011, 1, 16'h1111, 4'b0010);
    // weight0=3, weight1=1.
    tbl[15] = mk(1, 4'b0011, 4'b0011, 1, 16'h0013, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e;
      if (WEIGHTED) e = (k % 4 == 3) ? 4'b0010 : 4'b0001;
      else          e = (k % 2 == 1) ? 4'b0010 : 4'b0001;
      tbl[16+k] = mk(0, 4'b0011, 4'b0011, 1, 16'h0013, e);
    end
    // weight0=0 behaves as 1.
    tbl[24] = mk(0, 4'b0011, 4'b0011, 1, 16'h0010, 4'b0001);
    tbl[25] = mk(0, 4'b0011, 4'b0011, 1, 16'h0010, 4'b0010);
    tbl[26] = mk(0, 4'b0011, 4'b0011, 1, 16'h0010, 4'b0001);
    // Reset during requester 2's locked packet.
    tbl[27] = mk(0, 4'b0100, 4'b0000, 1, 16'h1111, 4'b0100);
    tbl[28] = mk(0, 4'b1111, 4'b0000, 1, 16'h1111, 4'b0100);
    tbl[29] = mk(1, 4'b1111, 4'b0000, 1, 16'h1111, 4'b0000);
    tbl[30] = mk(1, 4'b1111, 4'b1111, 1, 16'h1111, 4'b0000);
    tbl[31] = mk(0, 4'b1111, 4'b1111, 1, 16'h1111, 4'b0001);

    for (int k = 0; k < NVEC; k++) begin
      step(tbl[k].rst, tbl[k].valid, tbl[k].last, tbl[k].ready, tbl[k].weight, ge, ga);
      check($sformatf("vec%0d_grant", k), 32'(ga), 32'(tbl[k].exp_grant));
    end

    // Owner drops valid while locked: channel stalls, ownership kept.
    step(1, 4'b0000, 4'b0000, 1, 16'h1111, ge, ga);
    step(0, 4'b0110, 4'b0000, 1, 16'h1111, ge, ga);
    check("lock_start", 32'(ga), 32'h2);
    step(0, 4'b0100, 4'b0000, 1, 16'h1111, ge, ga);
    check("lock_hold_novalid", 32'(ga), 32'h2);
    check("lock_hold_outvalid", 32'(bus.out_valid), 32'h0);
    step(0, 4'b0110, 4'b0010, 1, 16'h1111, ge, ga);
    check("lock_release", 32'(ga), 32'h2);
    step(0, 4'b0100, 4'b0100, 1, 16'h1111, ge, ga);
    check("next_after_lock", 32'(ga), 32'h4);

    // Randomized packet traffic.
    step(1, 4'b0000, 4'b0000, 1, 16'h1111, ge, ga);
    for (int i = 0; i < WIDTH; i++) begin act[i] = 1'b0; left[i] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      v = '0; l = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (act[i]) begin v[i] = 1'b1; l[i] = (left[i] == 1); end
        w[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'($urandom_range(0, 3));
      end
      r  = ($urandom_range(0, 149) == 0);
      rd = ($urandom_range(0, 3) != 0);
      step(r, v, l, rd, w, ge, ga);
      if (!r) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (ge[i] && v[i] && rd) begin
            left[i]--;
            if (left[i] == 0) act[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i]  = 1'b1;
          left[i] = $urandom_range(1, 3);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
